imem_uart_loader: RTL and testbench
===================================

// Module: imem_uart_loader
// PURPOSE
//  Write side of the 32-bit instruction/data ROM. Takes a framed byte stream from
//  the UART receiver and writes 32-bit words into the memory's write port.
//  Holds the CPU in reset until a frame loads cleanly, so programs load at run
//  time instead of from a hex file at elaboration.
// PARAMETERS
//  WORDS      4096       memory depth in 32-bit words; longer frames are rejected
//  BASE_ADDR  32'h0      byte address of the first written word (word-aligned)
//  TIMEOUT    1_000_000  max clk cycles between bytes inside a frame
//  SYNC_BYTE  8'hA5      frame start marker
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  rx_data    in   8   received byte from UART RX
//  rx_valid   in   1   one-cycle strobe; rx_data is valid this cycle
//  mem_we     out  1   one-cycle write strobe to memory
//  mem_addr   out  32  byte address; always word-aligned, mem index = mem_addr[31:2]
//  mem_wdata  out  32  word to write
//  cpu_hold   out  1   1 = keep CPU in reset
//  load_done  out  1   sticky; last frame loaded and checksum matched
//  load_err   out  1   sticky; last frame failed
// BEHAVIOUR
//  Interface: one clock, clk; reset rst is synchronous, active-high.
//  Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1,
//  load_done=0, load_err=0, state=IDLE. A reset during a frame drops the frame.
//  Words already written stay in memory.
//  Frame format: SYNC, LEN[4 bytes, LE word count N], N words (4 bytes each, LE),
//  CSUM[1 byte] = XOR of every LEN and payload byte.
//  FSM:
//   IDLE: on rx_valid && rx_data==SYNC_BYTE -> LEN. Clear load_done/load_err.
//         Set cpu_hold=1 and reset word index and running XOR to 0.
//         Any other byte is ignored.
//   LEN : collect 4 bytes. If N > WORDS -> ERR. If N==0 -> CSUM. Otherwise -> DATA.
//   DATA: assemble 4 bytes LE, first byte = bits[7:0]. On the 4th byte, the next
//         cycle drives mem_we=1 for exactly one cycle, with
//         mem_addr = BASE_ADDR + 4*idx (32-bit wrap) and the assembled mem_wdata.
//         idx then increments. After word N is written -> CSUM.
//   CSUM: on byte, compare with the XOR. Match -> DONE, mismatch -> ERR.
//   DONE: load_done=1, cpu_hold=0 (same cycle DONE is entered, registered).
//         A new SYNC restarts the load (IDLE rules apply).
//   ERR : load_err=1, cpu_hold stays 1. A new SYNC restarts the load.
//  Timeout: in LEN/DATA/CSUM, a counter clears on each rx_valid. When it reaches
//  TIMEOUT -> ERR. The counter is inactive in IDLE/DONE/ERR.
//  Edge cases:
//   - rx_valid in the write cycle is accepted normally; the assembler is double-
//     buffered, so no byte is lost.
//   - The timeout firing and rx_valid in the same cycle: the byte wins and the
//     counter clears.
//   - A SYNC value inside LEN/DATA/CSUM is treated as data, not a restart.
//   - rx_valid back-to-back every cycle must be sustained.
// STRUCTURE
//  Shared header imem_loader_defs.vh: state encodings
//  (IDLE, LEN, DATA, CSUM, DONE, ERR) and the SYNC_BYTE default.
//  Sub-module byte_packer: shifts in 8-bit beats and flags word_full after 4
//  beats, LE order, with a sync clear input. It is reused for the LEN field and
//  for payload words. The FSM, address counter, XOR and timeout stay in the top.
// TESTING
//  1. Reset then idle.
//     -> cpu_hold=1, mem_we=0, load_done=0, load_err=0, mem_addr=BASE_ADDR.
//  2. Frame A5, 02 00 00 00, 13 00 00 00, 6F 00 00 00, CSUM=0x7E.
//     -> two mem_we pulses: (0x0, 0x00000013) and (0x4, 0x0000006F);
//        then load_done=1, cpu_hold=0.
//  3. Same frame with CSUM=0x00. -> both writes occur; load_err=1, cpu_hold=1.
//     Then a correct frame -> load_done=1, load_err=0.
//  4. LEN=4097 with WORDS=4096. -> ERR straight after LEN, no mem_we pulses.
//     LEN=0 with CSUM=00 -> load_done=1 with no writes.
//  5. TIMEOUT=16; send SYNC plus 2 LEN bytes, then idle 16 cycles -> load_err=1.
//     Also: gap of 15 cycles between bytes -> no error.
//  6. Assert rst mid-DATA after 6 bytes.
//     -> all outputs return to reset values the next cycle; a subsequent full
//        frame loads correctly from BASE_ADDR.
//  7. Back-to-back rx_valid every cycle for a 64-word frame.
//     -> 64 writes with sequential addresses and correct data; load_done=1.

Source files
------------

// File: rtl/imem_uart_loader_pkg.sv
// imem_uart_loader_pkg
//   Shared definitions for the UART program loader: FSM state encodings,
//   the default frame start marker and the word-address helper.
package imem_uart_loader_pkg;

  localparam int ST_W = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Byte address of word idx relative to base; wraps at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// imem_uart_loader_if
//   Bundles the UART byte stream, the memory write port, the CPU/status
//   outputs and the FSM state for the loader.
//   Handshake: rx_valid is a one-cycle strobe with no back-pressure; rx_data is
//   consumed in every cycle rx_valid is high. mem_we is a one-cycle write
//   strobe qualifying mem_addr/mem_wdata; the memory always accepts it.
//   master : the loader (consumes rx_*, drives everything else)
//   slave  : the environment (drives rx_*, observes the rest)
interface imem_uart_loader_if;
  import imem_uart_loader_pkg::*;

  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic            cpu_hold;
  logic            load_done;
  logic            load_err;
  logic [ST_W-1:0] state;

  modport master (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, state
  );

  modport slave (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, state
  );
endinterface

// File: rtl/imem_uart_loader_byte_packer.sv
// imem_uart_loader_byte_packer
//   Collects 8-bit beats into a 32-bit little-endian word (first beat lands in
//   bits [7:0]). word_full and word are combinational and valid in the cycle
//   the 4th beat arrives, so the caller can register the word immediately and
//   the packer is free to take the next beat in the following cycle.
// Ports
//   clk, rst    clock, synchronous active-high reset
//   clear       synchronous clear of the beat count and shift register
//   beat_valid  beat is valid this cycle
//   beat        8-bit input beat
//   word_full   this beat completes a word
//   word        assembled word (meaningful when word_full)
module imem_uart_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        beat_valid,
  input  logic [7:0]  beat,
  output logic        word_full,
  output logic [31:0] word
);
  logic [31:0] sh;
  logic [1:0]  cnt;

  assign word_full = beat_valid && (cnt == 2'd3);
  assign word      = {beat, sh[31:8]};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sh  <= '0;
      cnt <= '0;
    end else if (beat_valid) begin
      sh  <= {beat, sh[31:8]};
      cnt <= cnt + 2'd1; // wraps to 0 after the 4th beat
    end
  end
endmodule

// File: rtl/imem_uart_loader.sv
// imem_uart_loader
//   Receives a framed byte stream (SYNC, LEN[4 LE], N words [4 LE each],
//   CSUM = XOR of LEN and payload bytes) and writes the words to the
//   instruction memory, holding the CPU in reset until a frame loads cleanly.
// Parameters
//   WORDS      memory depth in words; frames longer than this are rejected
//   BASE_ADDR  byte address of the first written word
//   TIMEOUT    max clk cycles between bytes inside a frame
//   SYNC_BYTE  frame start marker
// Ports
//   clk, rst   clock, synchronous active-high reset
//   bus        loader side of imem_uart_loader_if (rx stream in, memory
//              write port, cpu_hold, load_done, load_err, state out)
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int          WORDS     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          TIMEOUT   = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  imem_uart_loader_if.master  bus
);
  localparam int            TCW     = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT - 1);
  localparam logic [31:0]   WORDS_U = 32'(WORDS);

  logic [ST_W-1:0] state;
  logic [31:0]     len;
  logic [31:0]     idx;
  logic [7:0]      acc;
  logic [TCW-1:0]  tcnt;

  logic            mem_we_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic            cpu_hold_q;
  logic            load_done_q;
  logic            load_err_q;

  logic            in_frame;
  logic            start;
  logic            pk_valid;
  logic            pk_full;
  logic [31:0]     pk_word;
  logic            timeout_hit;

  assign in_frame = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);

  // SYNC only restarts from a resting state; inside a frame it is plain data.
  assign start = bus.rx_valid && (bus.rx_data == SYNC_BYTE) &&
                 ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

  assign pk_valid = bus.rx_valid && ((state == ST_LEN) || (state == ST_DATA));

  // A byte arriving in the last allowed cycle wins over the timeout.
  assign timeout_hit = in_frame && !bus.rx_valid && (tcnt == TC_LAST);

  imem_uart_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .beat_valid (pk_valid),
    .beat       (bus.rx_data),
    .word_full  (pk_full),
    .word       (pk_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len         <= '0;
      idx         <= '0;
      acc         <= '0;
      tcnt        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;

      if (in_frame) begin
        tcnt <= bus.rx_valid ? '0 : tcnt + 1'b1;
      end

      if (pk_valid) begin
        acc <= acc ^ bus.rx_data;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state       <= ST_LEN;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            cpu_hold_q  <= 1'b1;
            idx         <= '0;
            acc         <= '0;
            tcnt        <= '0;
          end
        end
        ST_LEN: begin
          if (pk_full) begin
            len <= pk_word;
            if (pk_word > WORDS_U) begin
              state      <= ST_ERR;
              load_err_q <= 1'b1;
            end else if (pk_word == 32'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (pk_full) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= word_addr(BASE_ADDR, idx);
            mem_wdata_q <= pk_word;
            idx         <= idx + 32'd1;
            if (idx + 32'd1 == len) begin
              state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == acc) begin
              state       <= ST_DONE;
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
            end else begin
              state      <= ST_ERR;
              load_err_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (timeout_hit) begin
        state      <= ST_ERR;
        load_err_q <= 1'b1;
      end
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader
//   Self-checking bench for imem_uart_loader (WORDS=4096, BASE_ADDR=0,
//   TIMEOUT=16). Expected memory writes are queued as frames are driven and
//   popped by a write monitor.
module tb_imem_uart_loader;
  import imem_uart_loader_pkg::*;

  localparam int          W         = 64;
  localparam logic [31:0] BASE      = 32'h0;
  localparam int          DEPTH     = 4096;

  logic clk;
  logic rst;

  imem_uart_loader_if bus ();

  imem_uart_loader #(
    .WORDS     (DEPTH),
    .BASE_ADDR (BASE),
    .TIMEOUT   (16),
    .SYNC_BYTE (8'hA5)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic hold, input logic [2:0] st);
    check({tag, "_done"},  64'(bus.load_done), 64'(done));
    check({tag, "_err"},   64'(bus.load_err),  64'(err));
    check({tag, "_hold"},  64'(bus.cpu_hold),  64'(hold));
    check({tag, "_state"}, 64'(bus.state),     64'(st));
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin : wr_monitor
    logic [W-1:0] e;
    if (bus.mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {bus.mem_addr, bus.mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write", {bus.mem_addr, bus.mem_wdata}, e);
      end
    end
  end

  // ---------------- driver ----------------
  logic [31:0] pl[$];

  // Called and returns 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Sends a whole frame of n words taken from pl. Frames longer than the
  // memory stop after LEN because the loader rejects them there.
  task automatic send_frame(input logic [31:0] n, input int gap,
                            input bit force_csum, input logic [7:0] csum_val);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    send_byte(8'hA5, gap);
    for (int i = 0; i < 4; i++) begin
      b  = n[8*i +: 8];
      cs = cs ^ b;
      send_byte(b, gap);
    end
    if (n <= 32'(DEPTH)) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back({BASE + 32'(4 * i), pl[i]});
        for (int j = 0; j < 4; j++) begin
          b  = pl[i][8*j +: 8];
          cs = cs ^ b;
          send_byte(b, gap);
        end
      end
      send_byte(force_csum ? csum_val : cs, 0);
    end
  endtask

  task automatic wait_end(input string tag);
    int i;
    i = 0;
    while (!(bus.load_done || bus.load_err) && i < 40) begin
      @(posedge clk); #1;
      i++;
    end
    check({tag, "_wait_bound"}, 64'(i < 40), 64'd1);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // 1. reset state
    check_status("reset", 1'b0, 1'b0, 1'b1, ST_IDLE);
    check("reset_we",   64'(bus.mem_we),   64'd0);
    check("reset_addr", 64'(bus.mem_addr), 64'(BASE));
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check_status("idle", 1'b0, 1'b0, 1'b1, ST_IDLE);

    // Non-SYNC bytes in IDLE are ignored.
    send_byte(8'h13, 2);
    send_byte(8'h00, 2);
    check_status("idle_noise", 1'b0, 1'b0, 1'b1, ST_IDLE);

    // 2. two-word frame with good checksum (0x7E)
    pl.delete();
    pl.push_back(32'h0000_0013);
    pl.push_back(32'h0000_006F);
    send_frame(32'd2, 1, 1'b1, 8'h7E);
    wait_end("good2");
    check_status("good2", 1'b1, 1'b0, 1'b0, ST_DONE);

    // 3. same frame, wrong checksum, then recovery
    send_frame(32'd2, 0, 1'b1, 8'h00);
    wait_end("badcs");
    check_status("badcs", 1'b0, 1'b1, 1'b1, ST_ERR);
    send_frame(32'd2, 0, 1'b0, 8'h00);
    wait_end("recover");
    check_status("recover", 1'b1, 1'b0, 1'b0, ST_DONE);

    // 4. oversize length, then empty frame
    send_frame(32'd4097, 0, 1'b0, 8'h00);
    repeat (3) begin @(posedge clk); #1; end
    check_status("toolong", 1'b0, 1'b1, 1'b1, ST_ERR);
    check("toolong_queue", 64'(exp_q.size()), 64'd0);
    send_frame(32'd0, 0, 1'b0, 8'h00);
    wait_end("len0");
    check_status("len0", 1'b1, 1'b0, 1'b0, ST_DONE);

    // 5. timeout: 15 idle cycles tolerated, 16th fires
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 15);
    check_status("tmo_15", 1'b0, 1'b0, 1'b1, ST_LEN);
    @(posedge clk); #1;
    check_status("tmo_16", 1'b0, 1'b1, 1'b1, ST_ERR);

    // Full frame with a 15-cycle gap after every byte; SYNC value inside data.
    pl.delete();
    pl.push_back(32'hA5A5_12A5);
    send_frame(32'd1, 15, 1'b0, 8'h00);
    wait_end("gap15");
    check_status("gap15", 1'b1, 1'b0, 1'b0, ST_DONE);

    // 6. reset mid-DATA after 6 payload bytes (one word already written)
    pl.delete();
    pl.push_back(32'hDEAD_BEEF);
    pl.push_back(32'h1234_5678);
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({BASE, 32'hDEAD_BEEF});
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    check("pre_reset_state", 64'(bus.state), 64'(ST_DATA));
    rst = 1'b1;
    @(posedge clk); #1;
    check_status("midrst", 1'b0, 1'b0, 1'b1, ST_IDLE);
    check("midrst_we",   64'(bus.mem_we),    64'd0);
    check("midrst_addr", 64'(bus.mem_addr),  64'(BASE));
    check("midrst_data", 64'(bus.mem_wdata), 64'd0);
    check("midrst_queue", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(32'd2, 0, 1'b0, 8'h00);
    wait_end("after_rst");
    check_status("after_rst", 1'b1, 1'b0, 1'b0, ST_DONE);

    // 7. 64 random words back-to-back
    pl.delete();
    for (int i = 0; i < 64; i++) begin
      pl.push_back({16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))});
    end
    send_frame(32'd64, 0, 1'b0, 8'h00);
    wait_end("b2b64");
    check_status("b2b64", 1'b1, 1'b0, 1'b0, ST_DONE);

    repeat (4) begin @(posedge clk); #1; end
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
